datapath_trace_buffer: RTL and testbench

- Synthesizable trace buffer that captures per-instruction datapath state (pc, ALU result, packed control fields) into on-chip storage.
- Successor to per-cycle simulation printing; supports parametrised depth and width, a PC-match trigger, pre-trigger history (wrap mode) and a valid/ready readout port.
- Sits beside the single-cycle datapath, fed by its retire strobe; read out by a debug host after capture completes.

---
 rtl/datapath_trace_buffer_if.sv | 47 ++++
 rtl/datapath_trace_buffer.sv | 145 ++++++++++++++
 tb/tb_datapath_trace_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_trace_buffer_if.sv
// Capture, configuration and readout bundle for datapath_trace_buffer.
// rd_stamp is present only when TRACE_CYCLE_STAMP_EN is defined.
interface datapath_trace_buffer_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14,
  parameter int CW     = 5
);
  logic              cap_valid;
  logic [XLEN-1:0]   cap_pc;
  logic [XLEN-1:0]   cap_alu;
  logic [CTRL_W-1:0] cap_ctrl;
  logic              arm;
  logic              mode;
  logic              trig_en;
  logic [XLEN-1:0]   trig_pc;
  logic [CW-1:0]     post_count;
  logic              rd_valid;
  logic              rd_ready;
  logic [XLEN-1:0]   rd_pc;
  logic [XLEN-1:0]   rd_alu;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]       rd_stamp;
`endif

  modport master (
    output cap_valid, cap_pc, cap_alu, cap_ctrl, arm, mode, trig_en, trig_pc,
           post_count, rd_ready,
`ifdef TRACE_CYCLE_STAMP_EN
    input  rd_stamp,
`endif
    input  rd_valid, rd_pc, rd_alu, rd_ctrl, state, count, overflow, done
  );

  modport slave (
    input  cap_valid, cap_pc, cap_alu, cap_ctrl, arm, mode, trig_en, trig_pc,
           post_count, rd_ready,
`ifdef TRACE_CYCLE_STAMP_EN
    output rd_stamp,
`endif
    output rd_valid, rd_pc, rd_alu, rd_ctrl, state, count, overflow, done
  );
endinterface

// File: rtl/datapath_trace_buffer.sv
// Per-instruction trace buffer with PC trigger, wrap-mode history and fall-through readout.
// Optional TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp per entry (rd_stamp).
module datapath_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14,
  parameter int DEPTH  = 16
) (
  input logic clk,
  input logic rst_n,
  datapath_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, remaining_q, post_count_q;
  logic            overflow_q, mode_q, trig_en_q;
  logic [XLEN-1:0] trig_pc_q;
  logic            hit, wr_en, pop, full;

  logic [XLEN-1:0]   mem_pc   [DEPTH];
  logic [XLEN-1:0]   mem_alu  [DEPTH];
  logic [CTRL_W-1:0] mem_ctrl [DEPTH];

  assign hit  = bus.cap_valid && (!trig_en_q || bus.cap_pc == trig_pc_q);
  assign full = (count_q == CW'(DEPTH));
  assign pop  = (state_q == S_DONE) && (count_q != '0) && bus.rd_ready;

  // Wrap mode keeps recording non-matching retires while armed as history.
  always_comb begin
    wr_en = 1'b0;
    if (!bus.arm) begin
      case (state_q)
        S_ARMED: wr_en = hit || (mode_q && bus.cap_valid);
        S_POST:  wr_en = bus.cap_valid;
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (hit) state_d = (mode_q && post_count_q == '0) ? S_DONE : S_POST;
        S_POST: begin
          if (bus.cap_valid) begin
            if (mode_q ? (remaining_q == CW'(1)) : (count_q == CW'(DEPTH - 1)))
              state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      overflow_q   <= 1'b0;
      mode_q       <= 1'b0;
      trig_en_q    <= 1'b0;
      trig_pc_q    <= '0;
      post_count_q <= '0;
    end else if (bus.arm) begin
      state_q      <= S_ARMED;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      overflow_q   <= 1'b0;
      mode_q       <= bus.mode;
      trig_en_q    <= bus.trig_en;
      trig_pc_q    <= bus.trig_pc;
      post_count_q <= bus.post_count;
    end else begin
      state_q <= state_d;
      // A write into a full buffer drops the oldest entry; count stays at DEPTH.
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) begin
          rd_ptr     <= rd_ptr + AW'(1);
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end else if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_q <= count_q - CW'(1);
      end
      if (state_q == S_ARMED && hit)
        remaining_q <= post_count_q;
      else if (state_q == S_POST && bus.cap_valid && remaining_q != '0)
        remaining_q <= remaining_q - CW'(1);
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] mem_stamp [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc_q <= '0;
    else if (bus.arm)
      cyc_q <= '0;
    else if (state_q == S_ARMED || state_q == S_POST)
      cyc_q <= cyc_q + 32'd1;
  end

  assign bus.rd_stamp = mem_stamp[rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]    <= bus.cap_pc;
      mem_alu[wr_ptr]   <= bus.cap_alu;
      mem_ctrl[wr_ptr]  <= bus.cap_ctrl;
`ifdef TRACE_CYCLE_STAMP_EN
      mem_stamp[wr_ptr] <= cyc_q;
`endif
    end
  end

  assign bus.rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign bus.rd_pc    = mem_pc[rd_ptr];
  assign bus.rd_alu   = mem_alu[rd_ptr];
  assign bus.rd_ctrl  = mem_ctrl[rd_ptr];
  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_datapath_trace_buffer.sv
// Directed bench for datapath_trace_buffer at DEPTH=4: table-driven capture/readout
// plus hand sequences for backpressure, async reset, re-arm and optional stamps.
module tb_datapath_trace_buffer;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 14;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_trace_buffer_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CW(CW)) bus ();

  datapath_trace_buffer #(.XLEN(XLEN), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        arm;
    logic        mode;
    logic        ten;
    logic [31:0] tpc;
    logic [2:0]  post;
    logic        cv;
    logic [31:0] pc;
    logic        rdy;
    logic [1:0]  st;
    logic [2:0]  cnt;
    logic        rv;
    logic [31:0] rpc;
    logic        ov;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] alu_of(input logic [31:0] pc);
    return pc * 32'd7 + 32'h1234_0000;
  endfunction

  function automatic logic [13:0] ctrl_of(input logic [31:0] pc);
    return pc[15:2] ^ 14'h2A5;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cap(input logic cv, input logic [31:0] pc);
    bus.cap_valid = cv;
    bus.cap_pc    = pc;
    bus.cap_alu   = alu_of(pc);
    bus.cap_ctrl  = ctrl_of(pc);
  endtask

  task automatic add_arm(input logic mode, input logic ten, input logic [31:0] tpc,
                         input logic [2:0] post);
    vec_t v;
    v = '{arm: 1'b1, mode: mode, ten: ten, tpc: tpc, post: post, cv: 1'b1, pc: tpc,
          rdy: 1'b0, st: 2'd1, cnt: 3'd0, rv: 1'b0, rpc: 32'd0, ov: 1'b0};
    vq.push_back(v);
  endtask

  task automatic add(input logic cv, input logic [31:0] pc, input logic rdy,
                     input logic [1:0] st, input logic [2:0] cnt, input logic rv,
                     input logic [31:0] rpc, input logic ov);
    vec_t v;
    v = '{arm: 1'b0, mode: 1'b0, ten: 1'b0, tpc: 32'd0, post: 3'd0, cv: cv, pc: pc,
          rdy: rdy, st: st, cnt: cnt, rv: rv, rpc: rpc, ov: ov};
    vq.push_back(v);
  endtask

  task automatic do_arm(input logic mode, input logic ten, input logic [31:0] tpc,
                        input logic [2:0] post);
    bus.arm = 1'b1; bus.mode = mode; bus.trig_en = ten; bus.trig_pc = tpc;
    bus.post_count = post;
    drive_cap(1'b0, 32'd0);
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc);
    chk({nm, " rd_pc"}, bus.rd_pc, pc);
    chk({nm, " rd_alu"}, bus.rd_alu, alu_of(pc));
    chk({nm, " rd_ctrl"}, bus.rd_ctrl, ctrl_of(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.arm = 1'b0; bus.mode = 1'b0; bus.trig_en = 1'b0; bus.trig_pc = '0;
    bus.post_count = '0; bus.rd_ready = 1'b0;
    drive_cap(1'b0, 32'd0);

    // Stop-when-full: trigger at 0xC, capture window fills after 0x18.
    add(1, 32'hC, 0, 0, 0, 0, 0, 0);          // IDLE ignores retires
    add_arm(0, 1, 32'hC, 0);                   // retire in arm cycle not stored
    add(1, 32'h00, 0, 1, 0, 0, 0, 0);
    add(1, 32'h04, 0, 1, 0, 0, 0, 0);
    add(1, 32'h08, 0, 1, 0, 0, 0, 0);
    add(1, 32'h0C, 0, 2, 1, 0, 0, 0);
    add(1, 32'h10, 0, 2, 2, 0, 0, 0);
    add(1, 32'h14, 0, 2, 3, 0, 0, 0);
    add(1, 32'h18, 0, 3, 4, 1, 32'h0C, 0);
    add(1, 32'h1C, 0, 3, 4, 1, 32'h0C, 0);
    add(0, 32'h00, 1, 3, 3, 1, 32'h10, 0);
    add(0, 32'h00, 1, 3, 2, 1, 32'h14, 0);
    add(0, 32'h00, 1, 3, 1, 1, 32'h18, 0);
    add(0, 32'h00, 1, 3, 0, 0, 0, 0);
    add(0, 32'h00, 1, 3, 0, 0, 0, 0);
    // Wrap mode: trigger at 0x20, one post entry, history overwritten.
    add_arm(1, 1, 32'h20, 1);
    add(1, 32'h00, 0, 1, 1, 0, 0, 0);
    add(1, 32'h04, 0, 1, 2, 0, 0, 0);
    add(1, 32'h08, 0, 1, 3, 0, 0, 0);
    add(1, 32'h0C, 0, 1, 4, 0, 0, 0);
    add(1, 32'h10, 0, 1, 4, 0, 0, 1);
    add(1, 32'h14, 0, 1, 4, 0, 0, 1);
    add(1, 32'h18, 0, 1, 4, 0, 0, 1);
    add(1, 32'h1C, 0, 1, 4, 0, 0, 1);
    add(1, 32'h20, 0, 2, 4, 0, 0, 1);
    add(1, 32'h24, 0, 3, 4, 1, 32'h18, 1);
    add(1, 32'h28, 0, 3, 4, 1, 32'h18, 1);
    add(0, 32'h00, 1, 3, 3, 1, 32'h1C, 1);
    add(0, 32'h00, 1, 3, 2, 1, 32'h20, 1);
    add(0, 32'h00, 1, 3, 1, 1, 32'h24, 1);
    add(0, 32'h00, 1, 3, 0, 0, 0, 1);

    // Reset state.
    tick(); tick();
    chk("reset state", bus.state, 2'd0);
    chk("reset count", bus.count, 3'd0);
    chk("reset rd_valid", bus.rd_valid, 1'b0);
    chk("reset overflow", bus.overflow, 1'b0);
    chk("reset done", bus.done, 1'b0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      bus.arm = vq[i].arm;
      if (vq[i].arm) begin
        bus.mode = vq[i].mode; bus.trig_en = vq[i].ten;
        bus.trig_pc = vq[i].tpc; bus.post_count = vq[i].post;
      end
      drive_cap(vq[i].cv, vq[i].pc);
      bus.rd_ready = vq[i].rdy;
      tick();
      bus.arm = 1'b0;
      chk($sformatf("v%0d state", i), bus.state, vq[i].st);
      chk($sformatf("v%0d count", i), bus.count, vq[i].cnt);
      chk($sformatf("v%0d rd_valid", i), bus.rd_valid, vq[i].rv);
      chk($sformatf("v%0d overflow", i), bus.overflow, vq[i].ov);
      chk($sformatf("v%0d done", i), bus.done, vq[i].st == 2'd3);
      if (vq[i].rv) chk_head($sformatf("v%0d", i), vq[i].rpc);
    end
    bus.rd_ready = 1'b0;
    drive_cap(1'b0, 32'd0);

    // Immediate trigger, zero post entries: DONE in the first retire cycle.
    do_arm(1, 0, 32'h0, 0);
    chk("imm armed", bus.state, 2'd1);
    chk("imm ovf cleared", bus.overflow, 1'b0);
    drive_cap(1'b1, 32'h40);
    tick();
    drive_cap(1'b0, 32'd0);
    chk("imm state", bus.state, 2'd3);
    chk("imm count", bus.count, 3'd1);
    chk_head("imm", 32'h40);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("imm drained", bus.count, 3'd0);
    chk("imm rd_valid", bus.rd_valid, 1'b0);
    drive_cap(1'b1, 32'h44);
    tick();
    drive_cap(1'b0, 32'd0);
    chk("done no capture", bus.count, 3'd0);
    chk("done held", bus.state, 2'd3);

    // Readout backpressure, then re-arm from DONE with entries left.
    do_arm(0, 0, 32'h0, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      drive_cap(1'b1, 32'h100 + 32'(4 * k));
      tick();
    end
    drive_cap(1'b0, 32'd0);
    chk("bp state", bus.state, 2'd3);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d rd_valid", k), bus.rd_valid, 1'b1);
      chk($sformatf("bp%0d count", k), bus.count, 3'd4);
      chk_head($sformatf("bp%0d", k), 32'h100);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("bp pop count", bus.count, 3'd3);
    chk_head("bp pop", 32'h104);
    do_arm(0, 0, 32'h0, 0);
    chk("rearm state", bus.state, 2'd1);
    chk("rearm count", bus.count, 3'd0);

    // Asynchronous reset in the middle of POST.
    do_arm(1, 0, 32'h0, 3);
    drive_cap(1'b1, 32'h200); tick();
    drive_cap(1'b1, 32'h204); tick();
    drive_cap(1'b0, 32'd0);
    chk("mid post state", bus.state, 2'd2);
    chk("mid post count", bus.count, 3'd2);
    rst_n = 1'b0;
    #2;
    chk("async rst state", bus.state, 2'd0);
    chk("async rst count", bus.count, 3'd0);
    chk("async rst rd_valid", bus.rd_valid, 1'b0);
    chk("async rst overflow", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cap(1'b1, 32'h208);
    tick();
    drive_cap(1'b0, 32'd0);
    chk("post rst idle", bus.state, 2'd0);
    chk("post rst count", bus.count, 3'd0);

`ifdef TRACE_CYCLE_STAMP_EN
    // Stamp counter starts at 0 on the arm edge and advances each armed cycle.
    do_arm(1, 0, 32'h0, 1);
    tick(); tick();
    drive_cap(1'b1, 32'h300); tick();
    drive_cap(1'b0, 32'd0); tick(); tick();
    drive_cap(1'b1, 32'h304); tick();
    drive_cap(1'b0, 32'd0);
    chk("stamp state", bus.state, 2'd3);
    chk("stamp first", bus.rd_stamp, 32'd2);
    chk_head("stamp first", 32'h300);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("stamp second", bus.rd_stamp, 32'd5);
    chk_head("stamp second", 32'h304);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
